microseq_decoder_p: RTL and testbench



---
 rtl/microseq_decoder_p.sv | 117 +++++++++++
 tb/tb_microseq_decoder_p.sv | 119 +++++++++++
 2 files changed

// File: rtl/microseq_decoder_p.sv
// microseq_decoder_p: stateful microsequencer decoder (PC, R, return stack); in: clk rst_n id instr_in cc_in instr_en d_in; out: y y_oe pc_out r_out sp stack_full stack_empty ovf unf
module microseq_decoder_p #(
  parameter int ADDR_W = 12,
  parameter int STACK_DEPTH = 8,
  parameter int ID_W = 3,
  parameter logic [ID_W-1:0] DEC_ID = 3'b010
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [ID_W-1:0] id,
  input  logic [4:0] instr_in,
  input  logic cc_in,
  input  logic instr_en,
  input  logic [ADDR_W-1:0] d_in,
  output logic [ADDR_W-1:0] y,
  output logic y_oe,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] r_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic stack_full,
  output logic stack_empty,
  output logic ovf,
  output logic unf
);
  localparam int SW = $clog2(STACK_DEPTH+1);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [SW-1:0] SP1 = SW'(1);
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [ADDR_W-1:0] pc, r, pc1, tos, rd;
  logic [ADDR_W-1:0] n_pc, n_r, n_y;
  logic [SW-1:0] n_sp;
  logic n_oe, n_ovf, n_unf, push;
  assign pc_out = pc;
  assign r_out = r;
  assign stack_full = sp == SW'(STACK_DEPTH);
  assign stack_empty = sp == '0;
  assign pc1 = pc + ONE;
  assign rd = r + d_in;
  assign tos = stack[IW'(sp - SP1)];
  always_comb begin
    n_pc = pc;
    n_r = r;
    n_y = y;
    n_sp = sp;
    n_oe = 1'b0;
    n_ovf = ovf;
    n_unf = unf;
    push = 1'b0;
    if (id == DEC_ID) begin
      n_oe = 1'b1;
      if (instr_en) begin
        case (instr_in)
          5'b01000: begin n_y = pc; n_r = pc; n_pc = pc1; end
          5'b01001: begin n_y = rd; n_r = rd; n_pc = rd + ONE; end
          5'b01010: begin n_r = d_in; n_y = pc; n_pc = pc1; end
          5'b01011: begin
            n_y = pc;
            n_pc = pc1;
            push = !stack_full;
            n_sp = stack_full ? sp : sp + SP1;
            n_ovf = ovf | stack_full;
          end
          5'b01100: begin
            n_y = stack_empty ? pc : tos;
            n_pc = stack_empty ? pc1 : tos + ONE;
            n_sp = stack_empty ? sp : sp - SP1;
            n_unf = unf | stack_empty;
          end
          5'b01101: begin
            n_y = cc_in ? d_in : pc;
            n_pc = cc_in ? d_in + ONE : pc1;
          end
          5'b01110: begin
            // Nonzero R with a return address loops back to TOS; otherwise fall through, popping the loop entry when R ran out
            n_y = (r != '0 && !stack_empty) ? tos : pc;
            n_pc = (r != '0 && !stack_empty) ? tos + ONE : pc1;
            n_r = (r != '0 && !stack_empty) ? r - ONE : r;
            n_sp = (r == '0 && !stack_empty) ? sp - SP1 : sp;
            n_unf = unf | stack_empty;
          end
          5'b01111: begin
            n_y = '0;
            n_pc = '0;
            n_r = '0;
            n_sp = '0;
            n_ovf = 1'b0;
            n_unf = 1'b0;
          end
          default: n_oe = 1'b0;
        endcase
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      r <= '0;
      y <= '0;
      sp <= '0;
      y_oe <= 1'b0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      pc <= n_pc;
      r <= n_r;
      y <= n_y;
      sp <= n_sp;
      y_oe <= n_oe;
      ovf <= n_ovf;
      unf <= n_unf;
    end
  end
  always_ff @(posedge clk) begin
    if (push) stack[IW'(sp)] <= pc1;
  end
endmodule

// File: tb/tb_microseq_decoder_p.sv
// tb_microseq_decoder_p: table-driven bench for microseq_decoder_p
module tb_microseq_decoder_p;
  localparam logic [4:0] FP = 5'b01000, FRD = 5'b01001, LR = 5'b01010, PSH = 5'b01011;
  localparam logic [4:0] RET = 5'b01100, CJ = 5'b01101, LP = 5'b01110, CLR = 5'b01111;
  typedef struct {
    logic [2:0] id;
    logic [4:0] op;
    logic cc, en;
    logic [11:0] d, y;
    logic oe;
    logic [11:0] pc, r;
    logic [3:0] sp;
    logic ovf, unf;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, cc_in = 1'b0, instr_en = 1'b0;
  logic [2:0] id = 3'd0;
  logic [4:0] instr_in = 5'd0;
  logic [11:0] d_in = 12'd0;
  logic [11:0] y, pc_out, r_out;
  logic y_oe, stack_full, stack_empty, ovf, unf;
  logic [3:0] sp;
  int n_chk = 0, n_fail = 0;
  vec_t tv[$];
  microseq_decoder_p dut (
    .clk(clk), .rst_n(rst_n), .id(id), .instr_in(instr_in), .cc_in(cc_in),
    .instr_en(instr_en), .d_in(d_in), .y(y), .y_oe(y_oe), .pc_out(pc_out),
    .r_out(r_out), .sp(sp), .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf(ovf), .unf(unf)
  );
  always #5 clk = ~clk;
  task automatic chk(string n, int i, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", n, i, a, e);
    end
  endtask
  task automatic chk_all(int i, vec_t v);
    chk("y", i, 32'(y), 32'(v.y));
    chk("y_oe", i, 32'(y_oe), 32'(v.oe));
    chk("pc", i, 32'(pc_out), 32'(v.pc));
    chk("r", i, 32'(r_out), 32'(v.r));
    chk("sp", i, 32'(sp), 32'(v.sp));
    chk("ovf", i, 32'(ovf), 32'(v.ovf));
    chk("unf", i, 32'(unf), 32'(v.unf));
    chk("full", i, 32'(stack_full), 32'(v.sp == 4'd8));
    chk("empty", i, 32'(stack_empty), 32'(v.sp == 4'd0));
  endtask
  task automatic run(vec_t v, int i);
    @(negedge clk);
    id = v.id;
    instr_in = v.op;
    cc_in = v.cc;
    instr_en = v.en;
    d_in = v.d;
    @(posedge clk);
    #1;
    chk_all(i, v);
  endtask
  task automatic add(logic [2:0] i, logic [4:0] o, logic c, logic e, logic [11:0] dd,
                     logic [11:0] yy, logic oe, logic [11:0] p, logic [11:0] rr,
                     logic [3:0] s, logic ov, logic un);
    tv.push_back('{i, o, c, e, dd, yy, oe, p, rr, s, ov, un});
  endtask
  initial begin
    vec_t z;
    z = '{3'd0, 5'd0, 1'b0, 1'b0, 12'h0, 12'h0, 1'b0, 12'h0, 12'h0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) add(3'd2, FP, 0, 1, 12'h0, 12'(i), 1, 12'(i + 1), 12'(i), 0, 0, 0);
    add(3'd2, LR, 0, 1, 12'h100, 12'h004, 1, 12'h005, 12'h100, 0, 0, 0);
    add(3'd2, FRD, 0, 1, 12'h020, 12'h120, 1, 12'h121, 12'h120, 0, 0, 0);
    add(3'd2, LR, 0, 1, 12'hFFF, 12'h121, 1, 12'h122, 12'hFFF, 0, 0, 0);
    add(3'd2, FRD, 0, 1, 12'h002, 12'h001, 1, 12'h002, 12'h001, 0, 0, 0);
    add(3'd2, CLR, 0, 1, 12'h0, 12'h0, 1, 12'h0, 12'h0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      add(3'd2, PSH, 0, 1, 12'h0, 12'(i), 1, 12'(i + 1), 12'h0, (i < 8) ? 4'(i + 1) : 4'd8, i == 8, 0);
    for (int j = 0; j < 8; j++)
      add(3'd2, RET, 0, 1, 12'h0, 12'(8 - j), 1, 12'(9 - j), 12'h0, 4'(7 - j), 1, 0);
    add(3'd2, RET, 0, 1, 12'h0, 12'h002, 1, 12'h003, 12'h0, 0, 1, 1);
    add(3'd2, CLR, 0, 1, 12'h0, 12'h0, 1, 12'h0, 12'h0, 0, 0, 0);
    add(3'd2, CJ, 1, 1, 12'h00F, 12'h00F, 1, 12'h010, 12'h0, 0, 0, 0);
    add(3'd2, PSH, 0, 1, 12'h0, 12'h010, 1, 12'h011, 12'h0, 1, 0, 0);
    add(3'd2, LR, 0, 1, 12'h002, 12'h011, 1, 12'h012, 12'h002, 1, 0, 0);
    add(3'd2, LP, 0, 1, 12'h0, 12'h011, 1, 12'h012, 12'h001, 1, 0, 0);
    add(3'd2, LP, 0, 1, 12'h0, 12'h011, 1, 12'h012, 12'h000, 1, 0, 0);
    add(3'd2, LP, 0, 1, 12'h0, 12'h012, 1, 12'h013, 12'h000, 0, 0, 0);
    add(3'd2, CJ, 1, 1, 12'h3A0, 12'h3A0, 1, 12'h3A1, 12'h0, 0, 0, 0);
    add(3'd2, CJ, 0, 1, 12'h3A0, 12'h3A1, 1, 12'h3A2, 12'h0, 0, 0, 0);
    add(3'd3, FP, 0, 1, 12'h0, 12'h3A1, 0, 12'h3A2, 12'h0, 0, 0, 0);
    add(3'd2, FP, 0, 0, 12'h0, 12'h3A1, 1, 12'h3A2, 12'h0, 0, 0, 0);
    add(3'd2, 5'b00000, 0, 1, 12'h0, 12'h3A1, 0, 12'h3A2, 12'h0, 0, 0, 0);
    add(3'd2, PSH, 0, 1, 12'h0, 12'h3A2, 1, 12'h3A3, 12'h0, 1, 0, 0);
    add(3'd3, RET, 0, 1, 12'h0, 12'h3A2, 0, 12'h3A3, 12'h0, 1, 0, 0);
    add(3'd2, LP, 0, 1, 12'h0, 12'h3A3, 1, 12'h3A4, 12'h0, 0, 0, 0);
    add(3'd2, RET, 0, 1, 12'h0, 12'h3A4, 1, 12'h3A5, 12'h0, 0, 0, 1);
    add(3'd2, CLR, 0, 1, 12'h0, 12'h0, 1, 12'h0, 12'h0, 0, 0, 0);
    add(3'd2, LR, 0, 1, 12'h005, 12'h000, 1, 12'h001, 12'h005, 0, 0, 0);
    add(3'd2, LP, 0, 1, 12'h0, 12'h001, 1, 12'h002, 12'h005, 0, 0, 1);
    add(3'd2, CLR, 0, 1, 12'h0, 12'h0, 1, 12'h0, 12'h0, 0, 0, 0);
    add(3'd2, PSH, 0, 1, 12'h0, 12'h000, 1, 12'h001, 12'h0, 1, 0, 0);
    add(3'd2, LR, 0, 1, 12'h003, 12'h001, 1, 12'h002, 12'h003, 1, 0, 0);
    add(3'd2, LP, 0, 1, 12'h0, 12'h001, 1, 12'h002, 12'h002, 1, 0, 0);
    #12;
    chk_all(-1, z);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tv.size(); i++) run(tv[i], i);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all(900, z);
    id = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run('{3'd2, FP, 1'b0, 1'b1, 12'h0, 12'h000, 1'b1, 12'h001, 12'h000, 4'd0, 1'b0, 1'b0}, 901);
    run('{3'd2, RET, 1'b0, 1'b1, 12'h0, 12'h001, 1'b1, 12'h002, 12'h000, 4'd0, 1'b0, 1'b1}, 902);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
